// File: rtl/cpu_axi_bridge.sv
// SRAM-like inst/data request ports to a single AXI3 master: one read and one write outstanding.
// Optional BRIDGE_RAW_ADDR_CHECK_EN: block data reads only on a word-address match with the pending write.
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;
  logic        r_owner_data;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic [3:0]  w_strb;
  logic [31:0] w_data;
  logic        aw_done, w_done;

  logic r_idle, w_busy, raw_block;
  logic data_rd_go, inst_rd_go, data_wr_go;
  logic aw_hs, w_hs;

  assign r_idle = (r_state == R_IDLE);
  assign w_busy = (w_state != W_IDLE);

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
  assign raw_block = w_busy && (data_sram_addr[31:2] == w_addr[31:2]);
`else
  assign raw_block = w_busy;
`endif

  // A data read blocked by the RAW guard does not hold off an instruction fetch.
  assign data_rd_go = data_sram_req & ~data_sram_wr & r_idle & ~raw_block;
  assign inst_rd_go = inst_sram_req & r_idle & ~data_rd_go;
  assign data_wr_go = data_sram_req & data_sram_wr & ~w_busy;

  assign inst_sram_addr_ok = inst_rd_go;
  assign data_sram_addr_ok = data_rd_go | data_wr_go;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (data_rd_go | inst_rd_go) r_next = R_AR;
      R_AR:    if (arready) r_next = R_R;
      R_R:     if (rvalid) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (data_wr_go) w_next = W_REQ;
      W_REQ:   if ((aw_done | aw_hs) & (w_done | w_hs)) w_next = W_B;
      W_B:     if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Request latches and per-channel handshake tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner_data <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      w_addr       <= '0;
      w_size       <= '0;
      w_strb       <= '0;
      w_data       <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
    end else begin
      if (data_rd_go | inst_rd_go) begin
        r_owner_data <= data_rd_go;
        r_addr       <= data_rd_go ? data_sram_addr : inst_sram_addr;
        r_size       <= data_rd_go ? data_sram_size : inst_sram_size;
      end
      if (data_wr_go) begin
        w_addr  <= data_sram_addr;
        w_size  <= data_sram_size;
        w_strb  <= data_sram_wstrb;
        w_data  <= data_sram_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    arvalid           = (r_state == R_AR);
    rready            = (r_state == R_R);
    awvalid           = (w_state == W_REQ) & ~aw_done;
    wvalid            = (w_state == W_REQ) & ~w_done;
    bready            = (w_state == W_B);
    inst_sram_data_ok = rready & rvalid & ~r_owner_data;
    data_sram_data_ok = (rready & rvalid & r_owner_data) | (bready & bvalid);
  end

  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;

  assign arid    = r_owner_data ? DATA_ID : INST_ID;
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = DATA_ID;
  assign awaddr  = w_addr;
  assign awsize  = {1'b0, w_size};
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid   = DATA_ID;
  assign wdata = w_data;
  assign wstrb = w_strb;
  assign wlast = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: reads, arbitration, split write handshakes, RAW guard, async reset.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int total = 0;
  int bad   = 0;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic inst_read(input logic [31:0] a, input logic [31:0] d, input string tg);
    inst_sram_req = 1'b1; inst_sram_addr = a; inst_sram_size = 2'd2; arready = 1'b1;
    #1 chk({tg, "_aok"}, inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 1'b0;
    #1 chk({tg, "_arvalid"}, arvalid, 1);
    chk({tg, "_arid"}, arid, 0);
    chk({tg, "_araddr"}, araddr, a);
    chk({tg, "_arsize"}, arsize, 2);
    step();
    #1 chk({tg, "_rready"}, rready, 1);
    chk({tg, "_dok_early"}, inst_sram_data_ok, 0);
    step();
    rvalid = 1'b1; rdata = d;
    #1 chk({tg, "_dok"}, inst_sram_data_ok, 1);
    chk({tg, "_rdata"}, inst_sram_rdata, d);
    step();
    rvalid = 1'b0;
    #1 chk({tg, "_rready_off"}, rready, 0);
  endtask

  // Write to 0x80 held pending, data read of ra presented from the next cycle until accepted.
  task automatic raw_case(input logic [31:0] ra, input logic [31:0] wd, input int exp_acc,
                          input string tg);
    int acc = -1;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80; data_sram_size = 2'd2;
    data_sram_wdata = wd; data_sram_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    #1 chk({tg, "_wr_aok"}, data_sram_addr_ok, 1);
    step();
    for (int c = 1; c <= 8; c++) begin
      data_sram_req = (acc < 0); data_sram_wr = 1'b0; data_sram_addr = ra;
      bvalid = (c == 3);
      #1;
      if (c == 3) chk({tg, "_b_dok"}, data_sram_data_ok, 1);
      if (acc < 0 && data_sram_addr_ok) acc = c;
      step();
    end
    data_sram_req = 1'b0; bvalid = 1'b0;
    chk({tg, "_acc_cycle"}, acc, exp_acc);
    rvalid = 1'b1; rdata = wd;
    #1 chk({tg, "_rd_dok"}, data_sram_data_ok, 1);
    chk({tg, "_rd_data"}, data_sram_rdata, wd);
    step();
    rvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 0; inst_sram_size = 0; inst_sram_addr = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    #3;
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_oks", {inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}, 0);
    chk("rst_araddr", araddr, 0);
    chk("tied", {arlen, arburst, awlen, awburst, wlast}, {4'd0, 2'b01, 4'd0, 2'b01, 1'b1});
    step();
    resetn = 1'b1;
    step();

    // Lone instruction read
    inst_read(32'h1C00_0000, 32'h0280_0C0C, "ird");

    // Inst and data read together: data wins, inst follows after rvalid
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0008; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h100; data_sram_size = 2'd2;
    arready = 1'b1;
    #1 chk("arb_data_aok", data_sram_addr_ok, 1);
    chk("arb_inst_aok", inst_sram_addr_ok, 0);
    step();
    data_sram_req = 1'b0;
    #1 chk("arb_arid", arid, 1);
    chk("arb_araddr", araddr, 32'h100);
    chk("arb_inst_wait", inst_sram_addr_ok, 0);
    step();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1 chk("arb_data_dok", data_sram_data_ok, 1);
    chk("arb_inst_dok", inst_sram_data_ok, 0);
    chk("arb_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    chk("arb_inst_still", inst_sram_addr_ok, 0);
    step();
    rvalid = 1'b0;
    #1 chk("arb_inst_aok2", inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 1'b0;
    #1 chk("arb_arid2", arid, 0);
    chk("arb_araddr2", araddr, 32'h1C00_0008);
    step();
    rvalid = 1'b1; rdata = 32'h0000_1111;
    #1 chk("arb_inst_dok2", inst_sram_data_ok, 1);
    step();
    rvalid = 1'b0;

    // Write with delayed awready, parallel instruction read accepted same cycle
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80; data_sram_size = 2'd2;
    data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'b0011;
    awready = 1'b0; wready = 1'b1; arready = 1'b1;
    #1 chk("wr_inst_aok", inst_sram_addr_ok, 1);
    chk("wr_aok", data_sram_addr_ok, 1);
    step();
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    #1 chk("wr_vld1", {awvalid, wvalid}, 2'b11);
    chk("wr_awaddr", awaddr, 32'h80);
    chk("wr_wdata", wdata, 32'h1234_5678);
    chk("wr_wstrb", wstrb, 4'b0011);
    chk("wr_ids", {awid, wid, awsize}, {4'd1, 4'd1, 3'd2});
    chk("wr_par_arid", {arvalid, arid}, {1'b1, 4'd0});
    step();
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    #1 chk("wr_vld2", {awvalid, wvalid}, 2'b10);
    chk("wr_par_dok", {inst_sram_data_ok, data_sram_data_ok}, 2'b10);
    chk("wr_par_rdata", inst_sram_rdata, 32'hCAFE_F00D);
    step();
    rvalid = 1'b0; awready = 1'b1;
    #1 chk("wr_vld3", {awvalid, wvalid}, 2'b10);
    step();
    awready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h90;
    #1 chk("wr_b_state", {awvalid, wvalid, bready}, 3'b001);
    chk("wr_second_blk", data_sram_addr_ok, 0);
    chk("wr_dok_early", data_sram_data_ok, 0);
    step();
    data_sram_req = 1'b0; bvalid = 1'b1;
    #1 chk("wr_dok", data_sram_data_ok, 1);
    step();
    bvalid = 1'b0;
    #1 chk("wr_done", {bready, data_sram_data_ok}, 0);

    // RAW guard: different word, then same word
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    raw_case(32'h84, 32'hA5A5_0084, 1, "raw84");
`else
    raw_case(32'h84, 32'hA5A5_0084, 4, "raw84");
`endif
    raw_case(32'h80, 32'hA5A5_0080, 4, "raw80");

    // Async reset in R_R with a write also in flight
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0020;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h40;
    arready = 1'b1; awready = 1'b0; wready = 1'b0;
    step();
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    #1 chk("rst_pre_vld", {arvalid, awvalid, wvalid}, 3'b111);
    step();
    #1 chk("rst_pre_rr", rready, 1);
    resetn = 1'b0;
    #1 chk("rst_async", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_araddr_clr", araddr, 0);
    #2 resetn = 1'b1;
    step();
    inst_read(32'h1C00_0004, 32'h1122_3344, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
